// File: rtl/cdc_2phase_pkg.sv
// cdc_2phase_pkg: shared constants for the 2-phase CDC endpoints. Rev 1.0
`default_nettype none

package cdc_2phase_pkg;
  localparam int unsigned CDC_SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned CDC_FIFO_DEPTH_MAX      = 16;
endpackage

`default_nettype wire

// File: rtl/sync.sv
// sync: multi-flop synchronizer for a single asynchronous bit. Rev 1.0
`default_nettype none

module sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic serial_i,
  output logic serial_o
);
  // Only these flops may sample the asynchronous input; keep them together for CDC constraints.
  (* async_reg = "true" *) logic [STAGES-1:0] reg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q <= '0;
    end else begin
      reg_q <= {reg_q[STAGES-2:0], serial_i};
    end
  end

  assign serial_o = reg_q[STAGES-1];
endmodule

`default_nettype wire

// File: rtl/cdc_2phase_dst_fifo.sv
// cdc_2phase_dst_fifo: 2-phase req/ack receiving endpoint with a DEPTH-entry output FIFO. Rev 1.0
// Optional macro CDC_2PHASE_DST_FIFO_ASSERT_EN compiles in simulation-only protocol assertions.
`default_nettype none

module cdc_2phase_dst_fifo
  import cdc_2phase_pkg::*;
#(
  parameter type         T           = logic [31:0],
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned SYNC_STAGES = CDC_SYNC_STAGES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_req_i,
  input  T     async_data_i,
  output logic async_ack_o,
  output T     dst_data_o,
  output logic dst_valid_o,
  input  logic dst_ready_i
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 1 || DEPTH > CDC_FIFO_DEPTH_MAX) begin : g_bad_depth
      $fatal(1, "cdc_2phase_dst_fifo: DEPTH must be within 1..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "cdc_2phase_dst_fifo: SYNC_STAGES must be at least 2");
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic             req_sync;
  logic             req_seen_q, req_seen_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  T                 mem_q [DEPTH];
  logic             pending, push, pop;

  sync #(
    .STAGES (SYNC_STAGES)
  ) i_req_sync (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .serial_i (async_req_i),
    .serial_o (req_sync)
  );

  // Full is judged on the registered count: a pop frees a slot only from the next edge on.
  assign pending = (req_sync != req_seen_q);
  assign push    = pending && (count_q < CNT_W'(DEPTH));
  assign pop     = dst_valid_o && dst_ready_i;

  always_comb begin
    req_seen_d = req_seen_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (push) begin
      req_seen_d = ~req_seen_q;
      wptr_d     = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_seen_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      req_seen_q <= req_seen_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      if (push) begin
        mem_q[wptr_q] <= async_data_i;
      end
    end
  end

  assign async_ack_o = req_seen_q;
  assign dst_valid_o = (count_q != '0);
  assign dst_data_o  = mem_q[rptr_q];

`ifdef CDC_2PHASE_DST_FIFO_ASSERT_EN
  a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pending && !push) |=> $stable(async_data_i));
  a_one_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $changed(async_req_i) |-> ($past(async_req_i) == $past(async_ack_o)));
  a_stream_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dst_valid_o && !dst_ready_i) |=> (dst_valid_o && $stable(dst_data_o)));
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CNT_W'(DEPTH));
`endif
endmodule

`default_nettype wire

// File: tb/tb_cdc_2phase_dst_fifo.sv
// tb_cdc_2phase_dst_fifo: self-checking bench for cdc_2phase_dst_fifo (DEPTH=2 and DEPTH=3 instances). Rev 1.0
`default_nettype none

module tb_cdc_2phase_dst_fifo;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, ready, ack, valid;
  logic [31:0] data, dout;
  logic        req3, ready3, ack3, valid3;
  logic [31:0] data3, dout3;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  cdc_2phase_dst_fifo #(.T(logic [31:0]), .DEPTH(2), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_ni(rst_n), .async_req_i(req), .async_data_i(data),
    .async_ack_o(ack), .dst_data_o(dout), .dst_valid_o(valid), .dst_ready_i(ready)
  );

  cdc_2phase_dst_fifo #(.T(logic [31:0]), .DEPTH(3), .SYNC_STAGES(S)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .async_req_i(req3), .async_data_i(data3),
    .async_ack_o(ack3), .dst_data_o(dout3), .dst_valid_o(valid3), .dst_ready_i(ready3)
  );

  // Remote sender: toggle req with new data, then wait (bounded) for the matching ack.
  task automatic send(input logic [31:0] w, input string nm);
    bit ok = 1'b0;
    @(negedge clk);
    data = w;
    req  = ~req;
    for (int i = 0; i < 60; i++) begin
      if (ack === req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s ack timeout: ack=%b required=%b", nm, ack, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 0; data = 0; ready = 0;
    req3 = 0; data3 = 0; ready3 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (ack !== 1'b0)    begin n_fail++; $display("FAIL reset_ack actual=%b required=0", ack); end
    n_cmp++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid actual=%b required=0", valid); end
    n_cmp++; if (dout !== 32'h0)  begin n_fail++; $display("FAIL reset_data actual=%h required=0", dout); end
    n_cmp++; if (valid3 !== 1'b0) begin n_fail++; $display("FAIL reset_valid3 actual=%b required=0", valid3); end
  endtask

  task automatic test_single_toggle();
    ready = 1'b1;
    data  = 32'hDEADBEEF;
    req   = 1'b1;
    repeat (S) @(negedge clk);
    n_cmp++; if (ack !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early ack/valid actual=%b%b required=00", ack, valid);
    end
    @(negedge clk);
    n_cmp++; if (ack !== 1'b1 || valid !== 1'b1) begin
      n_fail++; $display("FAIL single_capture ack/valid actual=%b%b required=11", ack, valid);
    end
    n_cmp++; if (dout !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_data actual=%h required=deadbeef", dout);
    end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_pop valid actual=%b required=0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_fill();
    send(32'h1, "fill_w1");
    send(32'h2, "fill_w2");
    @(negedge clk);
    data = 32'h3;
    req  = ~req;
    repeat (10) @(negedge clk);
    n_cmp++; if (ack === req) begin n_fail++; $display("FAIL fill_withheld ack actual=%b required=%b", ack, ~req); end
    n_cmp++; if (valid !== 1'b1 || dout !== 32'h1) begin
      n_fail++; $display("FAIL fill_head actual=%b/%h required=1/00000001", valid, dout);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_cmp++; if (dout !== 32'h2 || ack === req) begin
      n_fail++; $display("FAIL fill_after_pop data/ack actual=%h/%b required=00000002/%b", dout, ack, ~req);
    end
    @(negedge clk);
    n_cmp++; if (ack !== req) begin n_fail++; $display("FAIL fill_late_capture ack actual=%b required=%b", ack, req); end
    ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (valid !== 1'b1 || dout !== 32'h3) begin
      n_fail++; $display("FAIL fill_order3 actual=%b/%h required=1/00000003", valid, dout);
    end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fill_drained valid actual=%b required=0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    send(a, "simul_a");
    @(negedge clk);
    data = b;
    req  = ~req;
    repeat (S) @(negedge clk);
    n_cmp++; if (dout !== a || ack === req) begin
      n_fail++; $display("FAIL simul_before data/ack actual=%h/%b required=%h/%b", dout, ack, a, ~req);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_cmp++; if (ack !== req || valid !== 1'b1 || dout !== b) begin
      n_fail++; $display("FAIL simul_after ack/valid/data actual=%b/%b/%h required=%b/1/%h", ack, valid, dout, req, b);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL simul_count1 valid actual=%b required=0", valid); end
  endtask

  task automatic test_reset_mid();
    send(32'h1, "rst_w1");
    send(32'h2, "rst_w2");
    @(negedge clk);
    data = 32'h3;
    req  = ~req;
    repeat (S + 3) @(negedge clk);
    rst_n = 1'b0; req = 1'b0; data = 32'h0; req3 = 1'b0;
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_async valid actual=%b required=0", valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0 || ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_state valid/ack actual=%b/%b required=0/0", valid, ack);
    end
    send(32'hA5, "rst_fresh");
    n_cmp++; if (valid !== 1'b1 || dout !== 32'hA5 || ack !== 1'b1) begin
      n_fail++; $display("FAIL rst_fresh valid/data/ack actual=%b/%h/%b required=1/000000a5/1", valid, dout, ack);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_fresh_pop valid actual=%b required=0", valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w = $urandom;
    send(w, "bp_send");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++; if (valid !== 1'b1 || dout !== w) begin
        n_fail++; $display("FAIL bp_hold cycle %0d actual=%b/%h required=1/%h", i, valid, dout, w);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_release valid actual=%b required=0", valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q[$];
    int got = 0;
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          logic [31:0] w = $urandom;
          bit ok = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          data3 = w;
          req3  = ~req3;
          exp_q.push_back(w);
          for (int i = 0; i < 100; i++) begin
            if (ack3 === req3) begin ok = 1'b1; break; end
            @(negedge clk);
          end
          if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL wrap_ack_timeout word %0d ack=%b required=%b", k, ack3, req3);
            break;
          end
        end
      end
      begin
        for (int cyc = 0; cyc < 5000 && got < 100; cyc++) begin
          bit r;
          @(negedge clk);
          r = 1'($urandom_range(0, 1));
          if (valid3 && r) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL wrap_extra actual=%h required=none", dout3);
            end else begin
              logic [31:0] e = exp_q.pop_front();
              if (dout3 !== e) begin
                n_fail++; $display("FAIL wrap_data item %0d actual=%h required=%h", got, dout3, e);
              end
            end
            got++;
          end
          ready3 = r;
        end
      end
    join
    @(negedge clk);
    ready3 = 1'b0;
    repeat (S + 3) @(negedge clk);
    n_cmp++; if (got != 100 || exp_q.size() != 0 || valid3 !== 1'b0) begin
      n_fail++; $display("FAIL wrap_total received=%0d left=%0d valid=%b required=100/0/0", got, exp_q.size(), valid3);
    end
  endtask

  initial begin
    test_reset();
    test_single_toggle();
    test_fill();
    test_simultaneous();
    test_reset_mid();
    test_backpressure();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule

`default_nettype wire
